// File: rtl/piano_pkg.sv
// Shared constants and bit-vector helpers for the piano front-end.
package piano_pkg;

   localparam int NUM_KEYS         = 8;
   localparam int DEBOUNCE_DEFAULT = 2_000_000;

   typedef logic [NUM_KEYS-1:0] key_vec_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

   function automatic logic is_onehot(input logic [7:0] v);
      return popcount8(v) == 4'd1;
   endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Button-side inputs and conditioned key outputs of the debounce stage.
interface key_debounce_if;
   import piano_pkg::*;

   key_vec_t key_raw;
   key_vec_t key;
   logic     key_valid;
   logic     press_pulse;
   logic     multi;

   modport slave  (input  key_raw, output key, key_valid, press_pulse, multi);
   modport master (output key_raw, input  key, key_valid, press_pulse, multi);

endinterface

// File: rtl/debounce_bit.sv
// One button: two-flop synchroniser, persistence counter and accepted level.
module debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             stab_q, stab_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count only while the synchronised level disagrees; any agreement restarts.
   always_comb begin
      stab_d = stab_q;
      cnt_d  = '0;
      if (sync_q[1] != stab_q) begin
         if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
         else                 stab_d = sync_q[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         stab_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], din};
         stab_q <= stab_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout = stab_q;

endmodule

// File: rtl/key_debounce.sv
// Eight debounced buttons reduced to a registered one-hot key, press strobe and multi flag.
module key_debounce
   import piano_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   key_debounce_if.slave  kif
);

   key_vec_t   stab;
   key_vec_t   key_q, key_d;
   logic       valid_q, valid_d;
   logic       pulse_q, pulse_d;
   logic       multi_q, multi_d;
   logic [3:0] n_held;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_bit
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk  (clk),
         .rst  (rst),
         .din  (kif.key_raw[g]),
         .dout (stab[g])
      );
   end

   // Comparing against the registered key catches none->one, multi->one and one->other.
   always_comb begin
      n_held  = popcount8(stab);
      valid_d = is_onehot(stab);
      key_d   = valid_d ? stab : '0;
      multi_d = n_held >= 4'd2;
      pulse_d = valid_d && (stab != key_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q   <= '0;
         valid_q <= 1'b0;
         pulse_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         key_q   <= key_d;
         valid_q <= valid_d;
         pulse_q <= pulse_d;
         multi_q <= multi_d;
      end
   end

   assign kif.key         = key_q;
   assign kif.key_valid   = valid_q;
   assign kif.press_pulse = pulse_q;
   assign kif.multi       = multi_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed and random key stimulus against a sliding-window model of the debouncer.
module tb_key_debounce;

   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   key_debounce_if kif();

   key_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk (clk),
      .rst (rst),
      .kif (kif.slave)
   );

   always #5 clk = ~clk;

   // Model: hist[0] is the newest raw sample; a bit is accepted once the
   // DC samples that have cleared the synchroniser all disagree with it.
   logic [7:0] hist[$];
   logic [7:0] m_stab, m_key;
   logic       m_valid, m_pulse, m_multi;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist = {};
      for (int k = 0; k <= DC; k++) hist.push_back(8'h00);
      m_stab = '0; m_key = '0; m_valid = 0; m_pulse = 0; m_multi = 0;
   endtask

   task automatic model_edge(input logic [7:0] raw, input logic r);
      int         n;
      logic [7:0] nstab;
      if (r) begin
         model_reset();
         return;
      end
      n       = $countones(m_stab);
      m_pulse = (n == 1) && (m_stab != m_key);
      m_key   = (n == 1) ? m_stab : 8'h00;
      m_valid = (n == 1);
      m_multi = (n >= 2);
      nstab = m_stab;
      for (int b = 0; b < 8; b++) begin
         bit all_diff = 1;
         for (int k = 1; k <= DC; k++) if (hist[k][b] == m_stab[b]) all_diff = 0;
         if (all_diff) nstab[b] = ~m_stab[b];
      end
      m_stab = nstab;
      hist.push_front(raw);
      void'(hist.pop_back());
   endtask

   task automatic step(input logic [7:0] raw, input logic r);
      @(negedge clk);
      chk("key",   kif.key,                m_key);
      chk("valid", {7'd0, kif.key_valid},   {7'd0, m_valid});
      chk("pulse", {7'd0, kif.press_pulse}, {7'd0, m_pulse});
      chk("multi", {7'd0, kif.multi},       {7'd0, m_multi});
      kif.key_raw = raw;
      rst = r;
      @(posedge clk);
      model_edge(raw, r);
      #1;
   endtask

   task automatic hold(input logic [7:0] raw, input int cycles);
      for (int i = 0; i < cycles; i++) step(raw, 1'b0);
   endtask

   initial begin
      int         pc;
      logic [7:0] v;
      kif.key_raw = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      chk("rst_key",   kif.key, 8'h00);
      chk("rst_valid", {7'd0, kif.key_valid}, 8'h00);
      chk("rst_pulse", {7'd0, kif.press_pulse}, 8'h00);
      chk("rst_multi", {7'd0, kif.multi}, 8'h00);
      hold(8'h00, 8);

      // clean press: edges 0..5 quiet, edge 6 key+pulse, edge 7 pulse drops
      hold(8'h04, 6);
      chk("press_early", kif.key, 8'h00);
      hold(8'h04, 1);
      chk("press_key",   kif.key, 8'h04);
      chk("press_valid", {7'd0, kif.key_valid}, 8'h01);
      chk("press_pulse", {7'd0, kif.press_pulse}, 8'h01);
      hold(8'h04, 1);
      chk("press_pulse_end", {7'd0, kif.press_pulse}, 8'h00);
      hold(8'h00, 8);

      // bounce rejection
      for (int i = 0; i < 20; i++) begin
         step(((i / 2) % 2 == 0) ? 8'h10 : 8'h00, 1'b0);
         chk("bounce_key", kif.key, 8'h00);
      end
      pc = 0;
      for (int i = 0; i < 7; i++) begin
         step(8'h10, 1'b0);
         if (kif.press_pulse) pc++;
         if (i < 6) chk("bounce_early", kif.key, 8'h00);
      end
      chk("bounce_final", kif.key, 8'h10);
      hold(8'h10, 3);
      if (kif.press_pulse) pc++;
      chk("bounce_npulse", 8'(pc), 8'd1);
      hold(8'h00, 8);

      // multi-key
      hold(8'h01, 8);
      hold(8'h81, 8);
      chk("multi_key",   kif.key, 8'h00);
      chk("multi_valid", {7'd0, kif.key_valid}, 8'h00);
      chk("multi_flag",  {7'd0, kif.multi}, 8'h01);
      pc = 0;
      for (int i = 0; i < 8; i++) begin
         step(8'h01, 1'b0);
         if (kif.press_pulse) pc++;
      end
      chk("multi_back_key",  kif.key, 8'h01);
      chk("multi_back_flag", {7'd0, kif.multi}, 8'h00);
      chk("multi_npulse",    8'(pc), 8'd1);

      // direct change with no gap
      hold(8'h02, 8);
      chk("direct_from", kif.key, 8'h02);
      pc = 0;
      for (int i = 0; i < 8; i++) begin
         step(8'h08, 1'b0);
         if (kif.press_pulse) pc++;
         chk("direct_nogap", {7'd0, (kif.key == 8'h02 || kif.key == 8'h08)}, 8'h01);
      end
      chk("direct_to",     kif.key, 8'h08);
      chk("direct_npulse", 8'(pc), 8'd1);

      // release
      hold(8'h20, 8);
      pc = 0;
      for (int i = 0; i < 7; i++) begin
         step(8'h00, 1'b0);
         if (kif.press_pulse) pc++;
         if (i < 6) chk("release_early", kif.key, 8'h20);
      end
      chk("release_key",    kif.key, 8'h00);
      chk("release_valid",  {7'd0, kif.key_valid}, 8'h00);
      chk("release_npulse", 8'(pc), 8'd0);

      // reset mid-count
      hold(8'h00, 8);
      hold(8'h40, 4);
      step(8'h40, 1'b1);
      chk("rstmid_key", kif.key, 8'h00);
      for (int i = 0; i < 6; i++) begin
         step(8'h40, 1'b0);
         chk("rstmid_early", kif.key, 8'h00);
      end
      step(8'h40, 1'b0);
      chk("rstmid_key_late", kif.key, 8'h40);

      // random segments
      for (int s = 0; s < 300; s++) begin
         case ($urandom_range(0, 3))
            0: v = 8'h00;
            1: v = 8'h01 << $urandom_range(0, 7);
            2: v = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
            default: v = 8'($urandom);
         endcase
         if ($urandom_range(0, 39) == 0) step(v, 1'b1);
         hold(v, $urandom_range(1, 9));
      end
      hold(8'h00, 8);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioning stage for the piano's eight note buttons. It synchronises the raw, bouncing push-button inputs into the clock domain and debounces each one. It then presents a clean, registered one-hot `key` vector to the note-index decoder, zero whenever no key or more than one key is held. It also produces a single-cycle press strobe and a multi-key flag for the recording/playback control logic.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: cycles a raw level must persist before it is accepted (20 ms at 100 MHz); legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width; derived, never overridden.

Ports:
- `clk`  in  1  system clock, one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `key_raw`  in  8  asynchronous button levels, 1 = pressed.
- `key`  out  8  debounced one-hot key, or 8'h00.
- `key_valid`  out  1  high whenever `key` is non-zero.
- `press_pulse`  out  1  one-cycle strobe on each new valid key.
- `multi`  out  1  high while two or more debounced keys are held.

## Operation
- **Synchroniser:** a two-flop synchroniser on each `key_raw` bit produces `sync[i]`.
- **Per-bit debounce:** each bit holds a stable level `stab[i]` and a counter `cnt[i]`.
  - `sync[i] == stab[i]`: `cnt[i] <= 0`.
  - Otherwise, while `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - Otherwise: `stab[i] <= sync[i]` and `cnt[i] <= 0`.
  - Any bounce back to the stable level before acceptance clears the counter; partial counts never carry over.
- **Output stage:** registered, one cycle after `stab`.
  - `key <= (popcount(stab)==1) ? stab : 8'h00`.
  - `key_valid <= (popcount(stab)==1)`.
  - `multi <= (popcount(stab)>=2)`.
  - `press_pulse <= (popcount(stab)==1) && (stab != key)`. This fires when going from no key to one key, from multi to one key, and from one key directly to a different one.
- **Release:** no strobe; `key` returns to 8'h00.
- **Reset:** clears synchronisers, every `stab`, every `cnt`, and all outputs. Reset values are `key`=8'h00, `key_valid`=0, `press_pulse`=0, `multi`=0. Asserted mid-count, reset discards the count. A key held through reset is re-accepted only after a full debounce interval following reset release.
- **Bit independence:** bits are fully independent; simultaneous edges on several bits are debounced in parallel.

## Timing
- Let cycle 0 be the first rising edge that samples a new `key_raw` level, with the level then held steady.
  - `sync` reflects the level after edge 1.
  - `stab` updates at edge `DEBOUNCE_CYCLES+1`.
  - `key`, `key_valid`, `multi` and `press_pulse` update at edge `DEBOUNCE_CYCLES+2`.
- Press and release latency are identical.
- `press_pulse` is high for exactly one cycle per qualifying transition, never for two consecutive cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never reaches the outputs.
- Counter arithmetic is unsigned, `CNT_W` bits; the counter never wraps because it saturates at the `DEBOUNCE_CYCLES-1` compare.

## Structure
- **Shared package `piano_pkg`:**
  - `NUM_KEYS = 8`.
  - `DEBOUNCE_DEFAULT = 2_000_000`.
  - Function `is_onehot(logic [7:0])`.
  - Function `popcount8`.
- **Sub-module `debounce_bit`:** one bit's synchroniser, counter and stable register. Ports are `clk`, `rst`, `din`, `dout`; parameter `DEBOUNCE_CYCLES`. It is instantiated `NUM_KEYS` times by a generate loop.
- **Top level:** keeps only the output register stage and the popcount/one-hot logic.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4`.
- **Clean press:** `key_raw`=8'h04 held from cycle 0 → `key`=8'h04, `key_valid`=1 and `press_pulse`=1 at edge 6. `press_pulse`=0 at edge 7. Outputs stay 0 before edge 6.
- **Bounce rejection:** `key_raw` toggles 8'h10/8'h00 every 2 cycles for 20 cycles, then holds 8'h10 → `key` remains 8'h00 throughout the toggling. `key`=8'h10 with a single `press_pulse` exactly 6 edges after the final steady edge.
- **Multi-key:** hold 8'h01, then add 8'h80 → `key`=8'h00, `key_valid`=0, `multi`=1. Release 8'h80 → `key`=8'h01, `press_pulse` fires once, `multi`=0.
- **Direct change:** 8'h02 released and 8'h08 pressed on the same edge → after debounce `key` goes 8'h02 → 8'h08 with no 8'h00 gap and exactly one `press_pulse`.
- **Release:** from 8'h20 held, `key_raw`=8'h00 → `key`=8'h00 and `key_valid`=0 six edges later, with no `press_pulse`.
- **Reset mid-count:** pulse `rst` for 1 cycle at count 2 of a press with 8'h40 held → all outputs 0 during and after reset. `key`=8'h40 appears only a full latency (6 edges) after `rst` deasserts.
